alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a serial restoring divider.
//   Single-cycle ops (logic, add/sub, shifts, multiply, NOT) and skip pass-through
//   finish one cycle after acceptance. DIV/MOD run one quotient bit per cycle,
//   then a sign-correction cycle, so their latency is WIDTH+2.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start            request, sampled only while idle
//   a, b, opcode     operands and operation select (0..11, 12-15 yield 0)
//   skip             pass b to y regardless of opcode
//   sig              signed compare / divide
//   y, bga, bea      registered result and b>a / b==a flags, updated on done
//   busy, done       busy while an operation is in flight; done pulses one cycle
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   input  logic             skip,
   input  logic             sig,
   output logic [WIDTH-1:0] y,
   output logic             bga,
   output logic             bea,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DIV  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam int CW = $clog2(WIDTH);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic             op_mod, neg_q, neg_r, dz, bga_r, bea_r;

   logic [SHW-1:0]   amt;
   logic             big;
   logic [WIDTH-1:0] alu_y, a_mag, b_mag, q_fix, r_fix;
   logic             bga_c, bea_c, is_div;
   logic [WIDTH:0]   rsh;
   logic [WIDTH+1:0] diff;

   // Single-cycle datapath, evaluated on the live inputs at acceptance.
   always_comb begin
      amt = b[SHW-1:0];
      big = amt >= SHW'(WIDTH);
      alu_y = '0;
      case (opcode)
         4'd0:  alu_y = a | b;
         4'd1:  alu_y = a & b;
         4'd2:  alu_y = a ^ b;
         4'd3:  alu_y = a + b;
         4'd4:  alu_y = a - b;
         4'd5:  alu_y = big ? '0 : a << amt;
         4'd6:  alu_y = big ? '0 : a >> amt;
         4'd7:  alu_y = a * b;
         4'd8:  alu_y = ~a;
         4'd11: alu_y = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> amt);
         default: alu_y = '0;
      endcase
      if (skip) alu_y = b;
   end

   assign bga_c  = sig ? ($signed(b) > $signed(a)) : (b > a);
   assign bea_c  = (a == b);
   assign is_div = !skip && (opcode == 4'd9 || opcode == 4'd10);
   assign a_mag  = (sig && a[WIDTH-1]) ? -a : a;
   assign b_mag  = (sig && b[WIDTH-1]) ? -b : b;

   // One restoring step: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits (extra bit catches borrow).
   assign rsh  = {rem, quo[WIDTH-1]};
   assign diff = {1'b0, rsh} - {2'b0, dvs};

   // With a zero divisor every step "fits", so the remainder ends up as |a|
   // and sign correction restores a; only the quotient needs forcing.
   // MIN / -1 falls out naturally: |MIN| / 1 = MIN with no negation.
   assign q_fix = dz ? '1 : (neg_q ? -quo : quo);
   assign r_fix = neg_r ? -rem : rem;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         op_mod <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         bga_r  <= 1'b0;
         bea_r  <= 1'b0;
         y      <= '0;
         bga    <= 1'b0;
         bea    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               if (is_div) begin
                  state  <= DIV;
                  cnt    <= '0;
                  rem    <= '0;
                  quo    <= a_mag;
                  dvs    <= b_mag;
                  op_mod <= (opcode == 4'd10);
                  neg_q  <= sig && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= sig && a[WIDTH-1];
                  dz     <= (b == '0);
                  // flags held back so outputs only move on the done load
                  bga_r  <= bga_c;
                  bea_r  <= bea_c;
               end else begin
                  state <= DONE;
                  y     <= alu_y;
                  bga   <= bga_c;
                  bea   <= bea_c;
               end
            end
            DIV: begin
               if (!diff[WIDTH+1]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rsh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               state <= DONE;
               y     <= op_mod ? r_fix : q_fix;
               bga   <= bga_r;
               bea   <= bea_r;
            end
            default: state <= IDLE;  // DONE
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
